// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the pipelined ALU.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_AND = 6'd2;
    localparam logic [5:0] OP_OR  = 6'd3;
    localparam logic [5:0] OP_XOR = 6'd4;
    localparam logic [5:0] OP_SLT = 6'd5;
    localparam logic [5:0] OP_SLL = 6'd6;
    localparam logic [5:0] OP_SRL = 6'd7;
    localparam logic [5:0] OP_MUL = 6'd8;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_result_fifo.sv
// In-order result FIFO; head output reads as zero while empty.
module alu_result_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign dout    = valid ? mem[rd_ptr] : '0;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with tagged result FIFO. Define ALU_PIPE_MUL_EN to enable the
// iterative shift-add multiplier (opcode 8); otherwise opcode 8 is unsupported.
module alu_pipe #(
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 5,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [TAG_W-1:0]  dest_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic              busy
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(DATA_W);
    localparam int FW   = DATA_W + TAG_W + 1;
    localparam int CW   = $clog2(OUT_DEPTH) + 1;

    logic              accept;
    logic              is_mul;
    logic              push;
    logic              mul_done;
    logic [FW-1:0]     din;
    logic [FW-1:0]     dout;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] alu_res;
    logic              alu_err;

    assign accept = in_valid && in_ready;
    assign push   = (accept && !is_mul) || mul_done;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (opcode)
            OP_ADD:  alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLL:  alu_res = op1 << op2[SH_W-1:0];
            OP_SRL:  alu_res = op1 >> op2[SH_W-1:0];
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_sum;
    logic [SH_W-1:0]   cnt;
    logic [TAG_W-1:0]  mtag;

    assign is_mul  = (opcode == OP_MUL);
    assign busy    = (state == MUL_BUSY);
    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign din     = mul_done ? {1'b0, mtag, acc_sum} : {alu_err, dest_tag, alu_res};
    // Accepts stop while busy, so the MUL's FIFO slot stays reserved until its push.
    assign in_ready = rst_n && (state == IDLE) && (count < CW'(OUT_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_done  = 1'b0;
        case (state)
            IDLE:     if (accept && is_mul) state_nxt = MUL_BUSY;
            MUL_BUSY: if (cnt == SH_W'(DATA_W-1)) begin
                          mul_done  = 1'b1;
                          state_nxt = IDLE;
                      end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            mtag   <= '0;
        end else if (accept && is_mul) begin
            mcand  <= op1;
            mplier <= op2;
            acc    <= '0;
            cnt    <= '0;
            mtag   <= dest_tag;
        end else if (state == MUL_BUSY) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign busy     = 1'b0;
    assign din      = {alu_err, dest_tag, alu_res};
    assign in_ready = rst_n && (count < CW'(OUT_DEPTH));
`endif

    alu_result_fifo #(
        .WIDTH (FW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (out_ready),
        .dout  (dout),
        .valid (out_valid),
        .count (count)
    );

    assign {out_err, out_tag, out_result} = dout;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus random traffic scored
// against an arithmetic reference model. Honors ALU_PIPE_MUL_EN.
module tb_alu_pipe;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    opcode = '0;
    logic [DW-1:0] op1 = '0;
    logic [DW-1:0] op2 = '0;
    logic [TW-1:0] dest_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_result;
    logic [TW-1:0] out_tag;
    logic          out_err;
    logic          busy;

    always #5 clk = ~clk;

    alu_pipe #(.DATA_W(DW), .TAG_W(TW), .OUT_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .op1        (op1),
        .op2        (op2),
        .dest_tag   (dest_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] tag);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint unsigned p2 = 64'd1 << b[4:0];
        int sa = int'(a);
        int sb = int'(b);
        exp_t e;
        e.tag = tag;
        e.err = 1'b0;
        e.res = '0;
        case (op)
            6'd0: e.res = 32'(ua + ub);
            6'd1: e.res = 32'(ua + (64'h1_0000_0000 - ub));
            6'd2: e.res = a & b;
            6'd3: e.res = a | b;
            6'd4: e.res = a ^ b;
            6'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
            6'd6: e.res = 32'(ua * p2);
            6'd7: e.res = 32'(ua / p2);
`ifdef ALU_PIPE_MUL_EN
            6'd8: e.res = 32'(ua * ub);
`endif
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard: records accepts, checks pops in order and head stability.
    bit            hold = 1'b0;
    logic [DW-1:0] h_res;
    logic [TW-1:0] h_tag;
    logic          h_err;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_res", 64'(out_result), 64'(h_res));
                chk("hold_tag", 64'(out_tag), 64'(h_tag));
                chk("hold_err", 64'(out_err), 64'(h_err));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("pop_unexpected", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    chk("sb_res", 64'(out_result), 64'(e.res));
                    chk("sb_tag", 64'(out_tag), 64'(e.tag));
                    chk("sb_err", 64'(out_err), 64'(e.err));
                end
            end
            hold  = out_valid && !out_ready;
            h_res = out_result;
            h_tag = out_tag;
            h_err = out_err;
            if (in_valid && in_ready) q.push_back(model(opcode, op1, op2, dest_tag));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
        bit got = 1'b0;
        in_valid = 1'b1;
        opcode   = op;
        op1      = a;
        op2      = b;
        dest_tag = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("send_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !out_valid && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", 64'(done), 64'd1);
        chk("drain_queue", 64'(q.size()), 64'd0);
        step();
    endtask

    initial begin
        int acc_n;
        logic rdy5;
        int bc;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // ADD wrap, latency 1
        out_ready = 1'b1;
        send(6'd0, 32'hFFFF_FFFF, 32'd1, 5'd3);
        @(negedge clk);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_res", 64'(out_result), 64'd0);
        chk("add_tag", 64'(out_tag), 64'd3);
        chk("add_err", 64'(out_err), 64'd0);
        step();

        send(6'd5, 32'h8000_0000, 32'd1, 5'd1);
        @(negedge clk);
        chk("slt_res", 64'(out_result), 64'd1);
        step();
        send(6'd7, 32'h8000_0000, 32'd31, 5'd2);
        @(negedge clk);
        chk("srl_res", 64'(out_result), 64'd1);
        step();

        // Unsupported opcode
        send(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21);
        @(negedge clk);
        chk("bad_valid", 64'(out_valid), 64'd1);
        chk("bad_res", 64'(out_result), 64'd0);
        chk("bad_err", 64'(out_err), 64'd1);
        chk("bad_tag", 64'(out_tag), 64'd21);
        drain();

        // Fill with consumer stalled
        out_ready = 1'b0;
        acc_n = 0;
        rdy5 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            opcode   = 6'd0;
            op1      = 32'(k * 10 + 1);
            op2      = 32'(k);
            dest_tag = 5'(k);
            @(negedge clk);
            if (in_ready) acc_n++;
            if (k == 4) rdy5 = in_ready;
            step();
        end
        in_valid = 1'b0;
        chk("fill_accepted", 64'(acc_n), 64'd4);
        chk("fill_5th_ready", 64'(rdy5), 64'd0);
        @(negedge clk);
        chk("fill_head", 64'(out_result), 64'd1);
        step();
        drain();

        // Multiply
`ifdef ALU_PIPE_MUL_EN
        out_ready = 1'b1;
        send(6'd8, 32'd7, 32'd6, 5'd9);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (i == 0) chk("mul_in_ready", 64'(in_ready), 64'd0);
            bc++;
        end
        chk("mul_busy_cycles", 64'(bc), 64'd32);
        chk("mul_valid", 64'(out_valid), 64'd1);
        chk("mul_res", 64'(out_result), 64'd42);
        chk("mul_tag", 64'(out_tag), 64'd9);
        chk("mul_err", 64'(out_err), 64'd0);
        step();
`else
        out_ready = 1'b1;
        send(6'd8, 32'd7, 32'd6, 5'd9);
        @(negedge clk);
        chk("mul_valid", 64'(out_valid), 64'd1);
        chk("mul_res", 64'(out_result), 64'd0);
        chk("mul_err", 64'(out_err), 64'd1);
        chk("mul_busy", 64'(busy), 64'd0);
        step();
`endif
        drain();

        // Reset in the middle of a MUL with two results queued
        out_ready = 1'b0;
        send(6'd0, 32'd1, 32'd2, 5'd4);
        send(6'd0, 32'd3, 32'd4, 5'd5);
        send(6'd8, 32'd100, 32'd200, 5'd6);
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmid_valid", 64'(out_valid), 64'd0);
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_in_ready", 64'(in_ready), 64'd1);
        step();
        out_ready = 1'b1;
        send(6'd0, 32'd5, 32'd6, 5'd2);
        @(negedge clk);
        chk("rmid_add_valid", 64'(out_valid), 64'd1);
        chk("rmid_add_res", 64'(out_result), 64'd11);
        chk("rmid_add_tag", 64'(out_tag), 64'd2);
        step();
        drain();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            opcode   = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(9, 63))
                                                    : 6'($urandom_range(0, 8));
            op1      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            op2      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            dest_tag = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
